// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: ShiftRows direction codes, row offsets,
// byte addressing within the column-major state, and block-width legality.
package aes_pkg;

    localparam logic SR_FWD = 1'b0;
    localparam logic SR_INV = 1'b1;

    // Rijndael shifts rows 2 and 3 one extra column for the 256-bit block.
    function automatic int row_offset(input int nb, input int r);
        return (nb == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

// File: rtl/aes_rowperm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module aes_rowperm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] in_data,
    input  logic             inv,
    output logic [32*NB-1:0] out_data
);

    localparam int W = 32 * NB;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_col
            for (gj = 0; gj < 4; gj++) begin : g_row
                localparam int OFF     = row_offset(NB, gj);
                localparam int DST     = byte_idx(gj, gi);
                localparam int SRC_FWD = byte_idx(gj, (gi + OFF) % NB);
                localparam int SRC_INV = byte_idx(gj, (gi - OFF + NB) % NB);

                // Byte k lives at the top of the word, so index from the MSB down.
                assign out_data[W-1-8*DST -: 8] = (inv == SR_INV)
                                                 ? in_data[W-1-8*SRC_INV -: 8]
                                                 : in_data[W-1-8*SRC_FWD -: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Elastic ShiftRows stage: permutation ahead of a bubble-collapsing register
// chain, with flush, sideband tag and a completed-block counter.
module aes_shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [CNT_W-1:0]   blk_count,
    output logic               busy
);

    localparam int W    = 32 * NB;
    localparam int LAST = PIPE_STAGES - 1;

    generate
        if (!nb_legal(NB) || PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_param_check
            $error("aes_shiftrows_pipe: illegal NB=%0d or PIPE_STAGES=%0d", NB, PIPE_STAGES);
        end
    endgenerate

    logic [W-1:0]            perm_data;
    logic [PIPE_STAGES-1:0]  stage_valid;
    logic [PIPE_STAGES-1:0]  stage_valid_d;
    logic [PIPE_STAGES-1:0]  adv;
    logic [W-1:0]            stage_data [PIPE_STAGES];
    logic [TAG_W-1:0]        stage_tag  [PIPE_STAGES];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q;

    aes_rowperm #(.NB(NB)) u_rowperm (
        .in_data  (in_data),
        .inv      (in_inv),
        .out_data (perm_data)
    );

    assign in_ready = adv[0] & ~flush & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            logic             vld_q, vld_d;
            logic [W-1:0]     data_q;
            logic [TAG_W-1:0] tag_q;
            logic             src_vld;
            logic [W-1:0]     src_data;
            logic [TAG_W-1:0] src_tag;

            if (gi == 0) begin : g_head
                assign src_vld  = in_valid & in_ready;
                assign src_data = perm_data;
                assign src_tag  = in_tag;
            end else begin : g_body
                assign src_vld  = stage_valid[gi-1];
                assign src_data = stage_data[gi-1];
                assign src_tag  = stage_tag[gi-1];
            end

            // A stage moves when any stage from here to the output has a hole,
            // or the output is draining; this is the unrolled advance chain.
            assign adv[gi] = out_ready | ~(&stage_valid[LAST:gi]);
            assign vld_d   = flush ? 1'b0 : (adv[gi] ? src_vld : vld_q);

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                    tag_q  <= '0;
                end else begin
                    vld_q <= vld_d;
                    if (adv[gi] && src_vld) begin
                        data_q <= src_data;
                        tag_q  <= src_tag;
                    end
                end
            end

            assign stage_valid[gi]   = vld_q;
            assign stage_valid_d[gi] = vld_d;
            assign stage_data[gi]    = data_q;
            assign stage_tag[gi]     = tag_q;
        end
    endgenerate

    assign out_valid = stage_valid[LAST];
    assign out_data  = stage_data[LAST];
    assign out_tag   = stage_tag[LAST];

    assign cnt_d = (out_valid && out_ready) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= |stage_valid_d;
        end
    end

    assign blk_count = cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Randomised and directed bench for aes_shiftrows_pipe against a row-rotation model.
module tb_aes_shiftrows_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: 128-bit block, three stages, 4-bit counter to exercise wrap.
    logic         a_flush = 1'b0, a_in_valid = 1'b0, a_in_inv = 1'b0, a_out_ready = 1'b0;
    logic         a_in_ready, a_out_valid, a_busy;
    logic [127:0] a_in_data = '0, a_out_data;
    logic [3:0]   a_in_tag = '0, a_out_tag, a_blk_count;

    aes_shiftrows_pipe #(.NB(4), .PIPE_STAGES(3), .TAG_W(4), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_inv(a_in_inv), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .blk_count(a_blk_count), .busy(a_busy)
    );

    // DUT B: 256-bit block, single stage, always-ready sink.
    logic         b_flush = 1'b0, b_in_valid = 1'b0, b_in_inv = 1'b0, b_out_ready = 1'b1;
    logic         b_in_ready, b_out_valid, b_busy;
    logic [255:0] b_in_data = '0, b_out_data;
    logic [3:0]   b_in_tag = '0, b_out_tag;
    logic [31:0]  b_blk_count;

    aes_shiftrows_pipe #(.NB(8), .PIPE_STAGES(1), .TAG_W(4), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_inv(b_in_inv), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .blk_count(b_blk_count), .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_recv   = 0;
    int model_cnt = 0;
    logic [131:0] exp_q[$];
    bit           hold_pending = 1'b0;
    logic [131:0] hold_val = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // State as a 4 x nb byte matrix; each row is rotated left (or right) whole.
    function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] din, input bit inv);
        logic [7:0]   st [4][8];
        logic [7:0]   tmp;
        logic [255:0] dout;
        int           w;
        int           sh;
        w    = 32 * nb;
        dout = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = din[w-1-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8 && r > 1) ? r + 1 : r;
            if (inv) sh = (nb - sh) % nb;
            for (int s = 0; s < sh; s++) begin
                tmp = st[r][0];
                for (int c = 0; c < nb - 1; c++) st[r][c] = st[r][c+1];
                st[r][nb-1] = tmp;
            end
        end
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                dout[w-1-8*(4*c+r) -: 8] = st[r][c];
        return dout;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle on DUT A: drive, then score whatever handshakes happen at the next edge.
    task automatic a_cycle(input bit offer, input bit rdy, input bit inv,
                           input logic [127:0] d, input logic [3:0] t);
        logic [255:0] r;
        logic [131:0] e;
        @(negedge clk);
        a_in_valid  = offer;
        a_out_ready = rdy;
        a_in_inv    = inv;
        a_in_data   = d;
        a_in_tag    = t;
        #1;
        if (hold_pending) begin
            check("hold_valid", a_out_valid, 1'b1);
            check("hold_data", {a_out_tag, a_out_data}, hold_val);
        end
        if (a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_data_tag", {a_out_tag, a_out_data}, e);
            end
            n_recv++;
            model_cnt++;
            $display("A out #%0d tag=%h data=%h", n_recv, a_out_tag, a_out_data);
        end
        if (a_in_valid && a_in_ready) begin
            r = ref_shift(4, {128'b0, d}, inv);
            exp_q.push_back({t, r[127:0]});
            n_acc++;
        end
        hold_pending = a_out_valid && !a_out_ready;
        hold_val     = {a_out_tag, a_out_data};
    endtask

    task automatic a_single(input string nm, input logic [127:0] d, input bit inv,
                            input logic [3:0] t, input logic [127:0] exp);
        int lat;
        int acc0;
        lat  = 0;
        acc0 = n_acc;
        a_cycle(1'b1, 1'b1, inv, d, t);
        check({nm, "_acc"}, n_acc - acc0, 1);
        while (!a_out_valid && lat < 10) begin
            a_cycle(1'b0, 1'b1, 1'b0, '0, '0);
            lat++;
        end
        check({nm, "_lat"}, lat, 3);
        check({nm, "_data"}, a_out_data, exp);
        check({nm, "_tag"}, a_out_tag, t);
    endtask

    task automatic b_xfer(input logic [255:0] d, input bit inv, input logic [3:0] t,
                          output logic [255:0] got);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_inv   = inv;
        b_in_tag   = t;
        #1;
        check("b_ready", b_in_ready, 1'b1);
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        check("b_valid", b_out_valid, 1'b1);
        check("b_tag", b_out_tag, t);
        got = b_out_data;
        $display("B out tag=%h inv=%0d data=%h", b_out_tag, inv, b_out_data);
    endtask

    initial begin
        logic [127:0] seq16, rd, exp128;
        logic [255:0] seq32, r1, r2, bd, be;
        logic [3:0]   cnt_before;
        bit           off;
        int           cyc;

        for (int k = 0; k < 16; k++) seq16[127-8*k -: 8] = 8'(k);
        for (int k = 0; k < 32; k++) seq32[255-8*k -: 8] = 8'(k);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", a_in_ready, 1'b0);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_out_data", a_out_data, '0);
        check("rst_out_tag", a_out_tag, '0);
        check("rst_blk_count", a_blk_count, '0);
        check("rst_busy", a_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", a_in_ready, 1'b1);

        // Ten random transfers with a randomly stalling sink
        cyc = 0;
        while (n_recv < 10 && cyc < 2000) begin
            off = (n_acc < 10) && ($urandom_range(0, 3) != 0);
            a_cycle(off, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd128(), 4'($urandom));
            cyc++;
        end
        check("rand_recv", n_recv, 10);
        check("rand_acc", n_acc, 10);
        check("rand_queue_empty", exp_q.size(), 0);
        a_cycle(1'b0, 1'b0, 1'b0, '0, '0);
        check("cnt_after_10", a_blk_count, 4'd10);

        // Directed vectors with latency measurement
        a_single("fips_fwd", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h5,
                 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        a_single("fips_inv", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'ha,
                 128'hd42711aee0bf98f1b8b45de51e415230);
        a_single("seq_fwd", seq16, 1'b0, 4'h3, 128'h00050a0f04090e03080d02070c01060b);

        // Full throughput: four back-to-back, then drain; count wraps 17 -> 1
        for (int i = 0; i < 4; i++) begin
            a_cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd128(), 4'(i));
            check("thru_ready", a_in_ready, 1'b1);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            a_cycle(1'b0, 1'b1, 1'b0, '0, '0);
            cyc++;
        end
        a_cycle(1'b0, 1'b1, 1'b0, '0, '0);
        check("cnt_wrap", a_blk_count, 4'd1);

        // Fill against a stalled sink, then flush with an output handshake
        for (int i = 0; i < 5; i++) a_cycle(1'b1, 1'b0, 1'b0, rnd128(), 4'(8 + i));
        check("full_ready", a_in_ready, 1'b0);
        check("full_busy", a_busy, 1'b1);
        check("full_depth", exp_q.size(), 3);
        cnt_before = a_blk_count;
        @(negedge clk);
        a_flush     = 1'b1;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        #1;
        check("flush_ready", a_in_ready, 1'b0);
        check("flush_out_valid", a_out_valid, 1'b1);
        @(negedge clk);
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        #1;
        check("post_flush_valid", a_out_valid, 1'b0);
        check("post_flush_busy", a_busy, 1'b0);
        check("post_flush_cnt", a_blk_count, 4'(cnt_before + 4'd1));
        exp_q.delete();
        hold_pending = 1'b0;
        model_cnt++;
        rd     = rnd128();
        r1     = ref_shift(4, {128'b0, rd}, 1'b1);
        exp128 = r1[127:0];
        a_single("after_flush", rd, 1'b1, 4'hc, exp128);
        a_cycle(1'b0, 1'b1, 1'b0, '0, '0);
        check("cnt_model", a_blk_count, 4'(model_cnt));

        // 256-bit block on DUT B
        b_xfer(seq32, 1'b0, 4'h1, r1);
        check("b_fwd_word", r1[255:224], 32'h00050e13);
        check("b_fwd_model", r1, ref_shift(8, seq32, 1'b0));
        b_xfer(r1, 1'b1, 4'h2, r2);
        check("b_inv_restore", r2, seq32);
        for (int i = 0; i < 6; i++) begin
            bd = {rnd128(), rnd128()};
            off = 1'(i);
            b_xfer(bd, off, 4'(i), r2);
            be = ref_shift(8, bd, off);
            check("b_rand", r2, be);
        end
        @(negedge clk);
        #1;
        check("b_count", b_blk_count, 32'd8);

        // Reset mid-stream
        a_cycle(1'b1, 1'b0, 1'b0, rnd128(), 4'h7);
        a_cycle(1'b1, 1'b0, 1'b0, rnd128(), 4'h6);
        @(negedge clk);
        rst        = 1'b1;
        a_in_valid = 1'b1;
        #1;
        check("midrst_ready", a_in_ready, 1'b0);
        @(negedge clk);
        #1;
        check("midrst_out_valid", a_out_valid, 1'b0);
        check("midrst_out_data", a_out_data, '0);
        check("midrst_out_tag", a_out_tag, '0);
        check("midrst_blk_count", a_blk_count, '0);
        check("midrst_busy", a_busy, 1'b0);
        rst        = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("midrst_release_ready", a_in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_shiftrows_pipe.md
# aes_shiftrows_pipe

Elastic, parametrised ShiftRows / InvShiftRows stage for the AES round datapath. Supports Rijndael block widths of 128, 192 and 256 bits, selected by parameter NB. The direction (forward or inverse) is chosen per transfer. Sits between SubBytes and MixColumns in the encrypt round and between InvShiftRows' neighbours in the decrypt round, with valid/ready handshakes on both sides, a configurable register depth, a sideband tag, a flush input and a completed-block counter.

## Interface
- NB, 4: state columns; legal values 4, 6, 8; block width W = 32*NB.
- PIPE_STAGES, 1: register stages; legal values 1 to 4.
- TAG_W, 4: sideband tag width, carried unchanged alongside the data.
- CNT_W, 32: width of the completed-block counter.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline clear; block counter kept.
- in_valid  in  1  input transfer offered.
- in_ready  out  1  stage can accept a transfer this cycle.
- in_data  in  W  input state.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  output transfer offered.
- out_ready  in  1  downstream accepts.
- out_data  out  W  permuted state.
- out_tag  out  TAG_W  sideband that travelled with out_data.
- blk_count  out  CNT_W  number of completed output transfers.
- busy  out  1  at least one stage holds valid data.

## Operation
- Byte layout: byte k occupies in_data[W-1-8k -: 8]. It is row k%4, column k/4, in column-major order, matching the existing round datapath.
- Row offsets off[r]:
  - NB=4 or 6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward: out(r,c) = in(r, (c+off[r]) mod NB).
- Inverse: out(r,c) = in(r, (c-off[r]+NB) mod NB).
- The permutation is purely combinational ahead of stage 0. The stages only register the result.
- Each stage holds a valid bit, data and tag. in_inv is consumed at the permutation and is not stored.
- Stage i advances when it is empty, or when stage i+1 advances. The last stage advances when out_ready is high.
- Empty stages collapse bubbles: a full stage moves into an empty successor even while the output is stalled.
- in_ready = (stage 0 empty or stage 0 advancing) and not flush and not rst. in_ready is combinational.
- out_valid, out_data and out_tag come straight from last-stage registers.
- Data must hold stable while out_valid is high and out_ready is low.
- blk_count increments on every cycle with out_valid and out_ready both high. It wraps from 2^CNT_W-1 to 0.
- flush clears every valid bit on the next edge. Any input offered in the same cycle is not accepted, because in_ready is 0. blk_count is unaffected, and an output handshake in the flush cycle is still counted.
- rst has priority over flush. rst clears all valid bits, data, tags and blk_count, including when asserted mid-stream.

## Timing
- Reset values: out_valid 0, out_data 0, out_tag 0, blk_count 0, busy 0. in_ready is 0 while rst is high and 1 in the first cycle after.
- Latency: an input accepted at edge n is presented at out_valid after edge n+PIPE_STAGES-1 (registered stage count), assuming out_ready stays high.
- Throughput: one transfer per cycle with out_ready held high.
- Full pipeline with out_ready low: in_ready goes low. No data is lost or duplicated.
- Simultaneous output handshake and input acceptance while full: allowed, no bubble inserted.
- busy = OR of all stage valid bits, registered.

## Structure
- Shared aes_pkg holds:
  - function row_offset(nb, r);
  - function byte_idx(r, c) = 4c+r;
  - constants SR_FWD=0 and SR_INV=1;
  - legal-NB check function, used in an elaboration-time assertion.
- One sub-module, aes_rowperm (NB parameter; in_data, inv to out_data, combinational), built from the generate loops over the package functions.
- The top level holds the elastic register chain (generate over PIPE_STAGES) and the counter.

## Test plan
- NB=4, forward, in_data d42711aee0bf98f1b8b45de51e415230 (FIPS-197 round 1 after SubBytes) -> out_data d4bf5d30e0b452aeb84111f11e2798e5 after PIPE_STAGES cycles, tag echoed.
- NB=4, inverse, in_data d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230. NB=4 forward with bytes 00..0f -> 00050a0f04090e03080d02070c01060b.
- NB=8, forward, bytes 00..1f -> leading word 00050e13. Then inverse of that result -> original 00..1f restored.
- PIPE_STAGES=3, back-to-back 10 transfers with out_ready randomly toggled -> in-order output, tags match, no drops or duplicates, blk_count=10.
- Pipeline full with out_ready=0, assert flush for one cycle -> out_valid=0 and busy=0 next cycle, blk_count unchanged; a new transfer is then accepted normally.
- Preload blk_count near wrap (CNT_W=4, 17 transfers) -> count reads 1. Assert rst mid-stream -> all outputs return to reset values next cycle.
